// File: rtl/regfile_pkg.sv
// Shared definitions for the pipelined register file: default sizes, index type
// and the one-hot decoder that builds per-register load/reserve vectors.
package regfile_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int NREG_DEF   = 8;
   localparam int ADDR_W_DEF = $clog2(NREG_DEF);

   // Widest register file the decoder serves; callers truncate to NREG bits.
   localparam int NREG_MAX   = 64;
   localparam int IDX_MAX_W  = $clog2(NREG_MAX);

   typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

   function automatic logic [NREG_MAX-1:0] onehot_dec(input logic [IDX_MAX_W-1:0] idx,
                                                      input logic                 en);
      logic [NREG_MAX-1:0] vec;
      vec = '0;
      if (en) begin
         vec[idx] = 1'b1;
      end
      return vec;
   endfunction

endpackage

// File: rtl/regfile_scb_regn.sv
// One DATA_W-wide architectural register with synchronous active-low reset and load enable.
module regN
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile_scb.sv
// NREG x DATA_W register file with one write port, two combinational read ports,
// optional write bypass and a busy scoreboard for read-after-write hazard detection.
module regfile_scb
   import regfile_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  NREG   = NREG_DEF,
   parameter int  BYPASS = 1,
   localparam int ADDR_W = $clog2(NREG)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] DR,
   input  logic [DATA_W-1:0] D,
   input  logic              LD_REG,
   input  logic [ADDR_W-1:0] SR1,
   input  logic [ADDR_W-1:0] SR2,
   output logic [DATA_W-1:0] SR1_out,
   output logic [DATA_W-1:0] SR2_out,
   output logic              SR1_busy,
   output logic              SR2_busy,
   input  logic              RSV,
   input  logic [ADDR_W-1:0] RSV_DR,
   output logic              RSV_ERR,
   output logic [NREG-1:0]   busy_vec
);

   logic [NREG-1:0]   load_vec;
   logic [NREG-1:0]   reserve_vec;
   logic [NREG-1:0]   busy_reg;
   logic [NREG-1:0]   busy_next;
   logic              rsv_err_reg;
   logic              rsv_err_next;
   logic [DATA_W-1:0] regs [NREG];

   assign load_vec    = NREG'(onehot_dec(IDX_MAX_W'(DR), LD_REG));
   assign reserve_vec = NREG'(onehot_dec(IDX_MAX_W'(RSV_DR), RSV));

   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      regN #(.DATA_W(DATA_W)) u_reg (
         .Clk   (Clk),
         .Reset (Reset),
         .load  (load_vec[gi]),
         .d     (D),
         .q     (regs[gi])
      );
   end

   // Reserve is OR-ed in after the release, so a same-index reserve keeps busy set.
   assign busy_next    = (busy_reg & ~load_vec) | reserve_vec;
   assign rsv_err_next = RSV & busy_reg[RSV_DR];

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         busy_reg    <= '0;
         rsv_err_reg <= 1'b0;
      end else begin
         busy_reg    <= busy_next;
         rsv_err_reg <= rsv_err_next;
      end
   end

   assign busy_vec = busy_reg;
   assign RSV_ERR  = rsv_err_reg;

   logic [ADDR_W-1:0] rd_idx  [2];
   logic [DATA_W-1:0] rd_data [2];
   logic              rd_busy [2];

   assign rd_idx[0] = SR1;
   assign rd_idx[1] = SR2;

   for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic hit;
      assign hit = LD_REG && (DR == rd_idx[gi]);
      // The release is visible early on the read port regardless of data bypass.
      assign rd_busy[gi] = busy_reg[rd_idx[gi]] & ~hit;
      if (BYPASS != 0) begin : g_byp
         assign rd_data[gi] = hit ? D : regs[rd_idx[gi]];
      end else begin : g_nobyp
         assign rd_data[gi] = regs[rd_idx[gi]];
      end
   end

   assign SR1_out  = rd_data[0];
   assign SR2_out  = rd_data[1];
   assign SR1_busy = rd_busy[0];
   assign SR2_busy = rd_busy[1];

endmodule

// File: tb/tb_regfile_scb.sv
// Directed bench for regfile_scb: default bypassing, non-bypassing, and a
// 16 x 32-bit instance, checked against hand-computed values.
module tb_regfile_scb;
   import regfile_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // Shared stimulus for the two 8 x 16 instances
   reg_idx_t    dr, sr1, sr2, rsv_dr;
   logic [15:0] d;
   logic        ld_reg, rsv;

   logic [15:0] b_sr1_out, b_sr2_out, n_sr1_out, n_sr2_out;
   logic        b_sr1_busy, b_sr2_busy, n_sr1_busy, n_sr2_busy;
   logic        b_rsv_err, n_rsv_err;
   logic [7:0]  b_busy_vec, n_busy_vec;

   // Stimulus for the 16 x 32 instance
   logic [3:0]  w_dr, w_sr1, w_sr2, w_rsv_dr;
   logic [31:0] w_d, w_sr1_out, w_sr2_out;
   logic        w_ld_reg, w_rsv, w_sr1_busy, w_sr2_busy, w_rsv_err;
   logic [15:0] w_busy_vec;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_scb #(.DATA_W(16), .NREG(8), .BYPASS(1)) dut_b (
      .Clk(clk), .Reset(reset), .DR(dr), .D(d), .LD_REG(ld_reg),
      .SR1(sr1), .SR2(sr2), .SR1_out(b_sr1_out), .SR2_out(b_sr2_out),
      .SR1_busy(b_sr1_busy), .SR2_busy(b_sr2_busy),
      .RSV(rsv), .RSV_DR(rsv_dr), .RSV_ERR(b_rsv_err), .busy_vec(b_busy_vec)
   );

   regfile_scb #(.DATA_W(16), .NREG(8), .BYPASS(0)) dut_nb (
      .Clk(clk), .Reset(reset), .DR(dr), .D(d), .LD_REG(ld_reg),
      .SR1(sr1), .SR2(sr2), .SR1_out(n_sr1_out), .SR2_out(n_sr2_out),
      .SR1_busy(n_sr1_busy), .SR2_busy(n_sr2_busy),
      .RSV(rsv), .RSV_DR(rsv_dr), .RSV_ERR(n_rsv_err), .busy_vec(n_busy_vec)
   );

   regfile_scb #(.DATA_W(32), .NREG(16), .BYPASS(1)) dut_w (
      .Clk(clk), .Reset(reset), .DR(w_dr), .D(w_d), .LD_REG(w_ld_reg),
      .SR1(w_sr1), .SR2(w_sr2), .SR1_out(w_sr1_out), .SR2_out(w_sr2_out),
      .SR1_busy(w_sr1_busy), .SR2_busy(w_sr2_busy),
      .RSV(w_rsv), .RSV_DR(w_rsv_dr), .RSV_ERR(w_rsv_err), .busy_vec(w_busy_vec)
   );

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ld_reg = 1'b0; rsv = 1'b0; w_ld_reg = 1'b0; w_rsv = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      ld_reg = 1'b1; dr = 3'd1; d = 16'hFFFF;
      rsv = 1'b1; rsv_dr = 3'd1; sr1 = 3'd1; sr2 = 3'd0;
      w_ld_reg = 1'b1; w_dr = 4'd1; w_d = 32'hFFFF_FFFF;
      w_rsv = 1'b1; w_rsv_dr = 4'd1; w_sr1 = 4'd1; w_sr2 = 4'd0;
      tick();
      tick();
      reset = 1'b1;
      idle();
      #1;
      n_cmp++; if (b_busy_vec !== 8'h00) begin n_bad++; $display("FAIL reset_busy: got %h expected 00", b_busy_vec); end
      n_cmp++; if (b_rsv_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsv_err: got %b expected 0", b_rsv_err); end
      n_cmp++; if (n_sr1_out !== 16'h0000) begin n_bad++; $display("FAIL reset_r1: got %h expected 0000", n_sr1_out); end
      n_cmp++; if (w_busy_vec !== 16'h0000) begin n_bad++; $display("FAIL reset_wide_busy: got %h expected 0000", w_busy_vec); end
      n_cmp++; if (w_sr1_out !== 32'h0) begin n_bad++; $display("FAIL reset_wide_r1: got %h expected 0", w_sr1_out); end
      $display("test_reset: done at %0t", $time);
   endtask

   task automatic test_write_read();
      ld_reg = 1'b1; dr = 3'd3; d = 16'h1234;
      tick();
      dr = 3'd7; d = 16'hBEEF;
      tick();
      idle();
      sr1 = 3'd3; sr2 = 3'd7;
      #1;
      n_cmp++; if (b_sr1_out !== 16'h1234) begin n_bad++; $display("FAIL wr_r3: got %h expected 1234", b_sr1_out); end
      n_cmp++; if (b_sr2_out !== 16'hBEEF) begin n_bad++; $display("FAIL wr_r7: got %h expected beef", b_sr2_out); end
      n_cmp++; if (n_sr1_out !== 16'h1234) begin n_bad++; $display("FAIL wr_r3_nb: got %h expected 1234", n_sr1_out); end
      n_cmp++; if ({b_sr1_busy, b_sr2_busy} !== 2'b00) begin n_bad++; $display("FAIL wr_busy: got %b expected 00", {b_sr1_busy, b_sr2_busy}); end
      $display("test_write_read: R3/R7 read back at %0t", $time);
   endtask

   task automatic test_bypass();
      ld_reg = 1'b1; dr = 3'd5; d = 16'hA5A5; sr1 = 3'd5; sr2 = 3'd5;
      #1;
      n_cmp++; if (b_sr1_out !== 16'hA5A5) begin n_bad++; $display("FAIL byp_sr1: got %h expected a5a5", b_sr1_out); end
      n_cmp++; if (b_sr2_out !== 16'hA5A5) begin n_bad++; $display("FAIL byp_sr2: got %h expected a5a5", b_sr2_out); end
      n_cmp++; if (n_sr1_out !== 16'h0000) begin n_bad++; $display("FAIL nobyp_old: got %h expected 0000", n_sr1_out); end
      tick();
      idle();
      #1;
      n_cmp++; if (n_sr2_out !== 16'hA5A5) begin n_bad++; $display("FAIL nobyp_new: got %h expected a5a5", n_sr2_out); end
      $display("test_bypass: R5 forwarded at %0t", $time);
   endtask

   task automatic test_reserve_release();
      rsv = 1'b1; rsv_dr = 3'd2;
      tick();
      idle();
      sr1 = 3'd2; sr2 = 3'd3;
      #1;
      n_cmp++; if (b_busy_vec !== 8'b0000_0100) begin n_bad++; $display("FAIL rsv_vec: got %b expected 00000100", b_busy_vec); end
      n_cmp++; if (b_sr1_busy !== 1'b1) begin n_bad++; $display("FAIL rsv_sr1_busy: got %b expected 1", b_sr1_busy); end
      n_cmp++; if (b_sr2_busy !== 1'b0) begin n_bad++; $display("FAIL rsv_sr2_idle: got %b expected 0", b_sr2_busy); end
      n_cmp++; if (b_rsv_err !== 1'b0) begin n_bad++; $display("FAIL rsv_no_err: got %b expected 0", b_rsv_err); end
      ld_reg = 1'b1; dr = 3'd2; d = 16'h0042;
      #1;
      n_cmp++; if (b_sr1_busy !== 1'b0) begin n_bad++; $display("FAIL rel_early: got %b expected 0", b_sr1_busy); end
      n_cmp++; if (n_sr1_busy !== 1'b0) begin n_bad++; $display("FAIL rel_early_nb: got %b expected 0", n_sr1_busy); end
      n_cmp++; if (b_sr1_out !== 16'h0042) begin n_bad++; $display("FAIL rel_data: got %h expected 0042", b_sr1_out); end
      n_cmp++; if (b_busy_vec !== 8'b0000_0100) begin n_bad++; $display("FAIL rel_vec_pre: got %b expected 00000100", b_busy_vec); end
      tick();
      idle();
      #1;
      n_cmp++; if (b_busy_vec !== 8'h00) begin n_bad++; $display("FAIL rel_vec_post: got %b expected 00000000", b_busy_vec); end
      n_cmp++; if (n_sr1_out !== 16'h0042) begin n_bad++; $display("FAIL rel_data_nb: got %h expected 0042", n_sr1_out); end
      $display("test_reserve_release: R2 reserved and released at %0t", $time);
   endtask

   task automatic test_same_index();
      rsv = 1'b1; rsv_dr = 3'd4; ld_reg = 1'b1; dr = 3'd4; d = 16'h00FF;
      tick();
      idle();
      sr1 = 3'd4; sr2 = 3'd4;
      #1;
      n_cmp++; if (n_sr1_out !== 16'h00FF) begin n_bad++; $display("FAIL same_data: got %h expected 00ff", n_sr1_out); end
      n_cmp++; if (b_busy_vec !== 8'b0001_0000) begin n_bad++; $display("FAIL same_vec: got %b expected 00010000", b_busy_vec); end
      n_cmp++; if ({b_sr1_busy, b_sr2_busy} !== 2'b11) begin n_bad++; $display("FAIL same_busy: got %b expected 11", {b_sr1_busy, b_sr2_busy}); end
      $display("test_same_index: R4 written and kept busy at %0t", $time);
   endtask

   task automatic test_back_to_back();
      rsv = 1'b1; rsv_dr = 3'd1;
      tick();
      n_cmp++; if (b_rsv_err !== 1'b0) begin n_bad++; $display("FAIL b2b_first: got %b expected 0", b_rsv_err); end
      tick();
      idle();
      #1;
      n_cmp++; if (b_rsv_err !== 1'b1) begin n_bad++; $display("FAIL b2b_second: got %b expected 1", b_rsv_err); end
      n_cmp++; if (n_rsv_err !== 1'b1) begin n_bad++; $display("FAIL b2b_second_nb: got %b expected 1", n_rsv_err); end
      n_cmp++; if (b_busy_vec !== 8'b0001_0010) begin n_bad++; $display("FAIL b2b_vec: got %b expected 00010010", b_busy_vec); end
      tick();
      n_cmp++; if (b_rsv_err !== 1'b0) begin n_bad++; $display("FAIL b2b_pulse: got %b expected 0", b_rsv_err); end
      $display("test_back_to_back: double reserve of R1 at %0t", $time);
   endtask

   task automatic test_reset_mid();
      rsv = 1'b1; rsv_dr = 3'd0;
      tick();
      rsv_dr = 3'd6; ld_reg = 1'b1; dr = 3'd6; d = 16'h7777;
      tick();
      idle();
      sr1 = 3'd6; sr2 = 3'd3;
      #1;
      n_cmp++; if (b_busy_vec !== 8'b0101_0011) begin n_bad++; $display("FAIL mid_vec: got %b expected 01010011", b_busy_vec); end
      n_cmp++; if (b_sr1_out !== 16'h7777) begin n_bad++; $display("FAIL mid_r6: got %h expected 7777", b_sr1_out); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      n_cmp++; if (b_busy_vec !== 8'h00) begin n_bad++; $display("FAIL mid_rst_vec: got %b expected 00000000", b_busy_vec); end
      n_cmp++; if (b_sr1_out !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_r6: got %h expected 0000", b_sr1_out); end
      n_cmp++; if (n_sr2_out !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_r3: got %h expected 0000", n_sr2_out); end
      $display("test_reset_mid: reservations discarded at %0t", $time);
   endtask

   task automatic test_wide();
      w_rsv = 1'b1; w_rsv_dr = 4'd15; w_ld_reg = 1'b1; w_dr = 4'd0; w_d = 32'h0123_4567;
      tick();
      idle();
      w_sr1 = 4'd15; w_sr2 = 4'd0;
      #1;
      n_cmp++; if (w_busy_vec !== 16'h8000) begin n_bad++; $display("FAIL wide_vec: got %h expected 8000", w_busy_vec); end
      n_cmp++; if (w_sr1_busy !== 1'b1) begin n_bad++; $display("FAIL wide_r15_busy: got %b expected 1", w_sr1_busy); end
      n_cmp++; if (w_sr2_out !== 32'h0123_4567) begin n_bad++; $display("FAIL wide_r0: got %h expected 01234567", w_sr2_out); end
      w_ld_reg = 1'b1; w_dr = 4'd15; w_d = 32'hDEAD_BEEF; w_rsv = 1'b1; w_rsv_dr = 4'd15;
      #1;
      n_cmp++; if (w_sr1_out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wide_byp: got %h expected deadbeef", w_sr1_out); end
      n_cmp++; if (w_sr1_busy !== 1'b0) begin n_bad++; $display("FAIL wide_rel: got %b expected 0", w_sr1_busy); end
      tick();
      idle();
      #1;
      n_cmp++; if (w_rsv_err !== 1'b1) begin n_bad++; $display("FAIL wide_err: got %b expected 1", w_rsv_err); end
      n_cmp++; if (w_busy_vec !== 16'h8000) begin n_bad++; $display("FAIL wide_keep: got %h expected 8000", w_busy_vec); end
      n_cmp++; if (w_sr2_out !== 32'h0123_4567) begin n_bad++; $display("FAIL wide_r0_intact: got %h expected 01234567", w_sr2_out); end
      $display("test_wide: 16x32 R15 boundary at %0t", $time);
   endtask

   initial begin
      reset = 1'b0;
      idle();
      dr = '0; d = '0; sr1 = '0; sr2 = '0; rsv_dr = '0;
      w_dr = '0; w_d = '0; w_sr1 = '0; w_sr2 = '0; w_rsv_dr = '0;
      #1;
      test_reset();
      test_write_read();
      test_bypass();
      test_reserve_release();
      test_same_index();
      test_back_to_back();
      test_reset_mid();
      test_wide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_scb.md
# regfile_scb

Parametrised successor to the LC-3 eight-entry register file for the pipelined datapath. It provides NREG registers of DATA_W bits with one write port, two combinational read ports, optional write-to-read bypass, and a per-register busy scoreboard. The scoreboard lets the decode stage detect read-after-write hazards against in-flight producers. It sits between decode (read/reserve) and writeback (write/release).

## Interface
- DATA_W, 16, register width in bits
- NREG, 8, number of registers; power of two, at least 2
- ADDR_W, $clog2(NREG), register index width (derived, not overridden)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads show pre-write contents

Ports:
- Clk  input  1  rising-edge clock; the only clock
- Reset  input  1  synchronous, active-low reset
- DR  input  ADDR_W  write destination index
- D  input  DATA_W  write data
- LD_REG  input  1  write enable; also releases DR's busy bit
- SR1, SR2  input  ADDR_W  read indices
- SR1_out, SR2_out  output  DATA_W  read data
- SR1_busy, SR2_busy  output  1  source has an outstanding producer
- RSV  input  1  reserve request (decode issued a producer)
- RSV_DR  input  ADDR_W  register to reserve
- RSV_ERR  output  1  registered; pulses when RSV targets an already-busy register
- busy_vec  output  NREG  full scoreboard, for debug and the stall unit

## Operation
- Reset low at a rising edge clears all registers to 0, all busy bits to 0, and RSV_ERR to 0. RSV and LD_REG are ignored in that cycle. Reset mid-operation discards every pending reservation.
- Write: when LD_REG=1 at a rising edge, reg[DR] <= D and busy[DR] <= 0.
- Read is combinational: SRn_out = reg[SRn].
  - If BYPASS=1 and LD_REG=1 and DR==SRn, then SRn_out = D.
- Busy output: SRn_busy = busy[SRn].
  - If LD_REG=1 and DR==SRn, SRn_busy is forced 0 in the same cycle (the release is visible early). This applies whether BYPASS is 0 or 1.
- Reserve: when RSV=1 at a rising edge, busy[RSV_DR] <= 1.
- Simultaneous LD_REG and RSV on the same index: reserve wins, busy stays 1. The write data still lands in the register.
- Simultaneous LD_REG and RSV on different indices: both take effect.
- RSV_ERR <= RSV && busy[RSV_DR] (the pre-edge value). The reservation still takes effect. RSV_ERR is a sticky-free, one-cycle pulse.
- Both read ports may address the same register. Every read returns identical data and busy.
- Write with no prior reservation is legal: the data lands and busy is unchanged at 0.

## Timing
- Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Reserve-to-busy latency: 1 cycle; busy is visible the cycle after RSV is sampled.
- Release: combinational through the read-port override; busy_vec updates after the edge.
- RSV_ERR: asserted 1 cycle after the offending RSV.
- No handshakes and no back-pressure. All inputs are sampled every cycle.
- busy_vec reflects only registered state. No same-cycle override applies to it.

## Structure
- Shared package regfile_pkg holds:
  - the localparams DATA_W_DEF=16 and NREG_DEF=8;
  - the typedef reg_idx_t (logic [ADDR_W-1:0]);
  - the function onehot_dec(idx, en), which returns an NREG-bit load vector.
- Sub-module regN: a DATA_W-wide register with synchronous active-low Reset and a load enable. It is instantiated NREG times via generate, with load = onehot_dec(DR, LD_REG)[i].
- The scoreboard is inline in regfile_scb: one NREG-bit register with next-state logic of the form (busy & ~release) | reserve.
- The read muxes are a generate-built array index. There is no per-index case list.

## Test plan
- Reset sequence, then write R3=16'h1234 and R7=16'hBEEF. Read SR1=3, SR2=7 next cycle → 16'h1234 and 16'hBEEF, both busy=0.
- BYPASS=1, LD_REG=1, DR=5, D=16'hA5A5, SR1=SR2=5 in the same cycle → both outputs 16'hA5A5 combinationally. Rerun with BYPASS=0 → old value 16'h0000, then 16'hA5A5 one cycle later.
- RSV with RSV_DR=2 → busy_vec=8'b0000_0100 next cycle and SR1_busy=1 for SR1=2. Then LD_REG with DR=2, D=16'h0042 → SR1_busy=0 in that cycle and the data reads 16'h0042.
- Same-cycle RSV_DR=4 and LD_REG DR=4, D=16'h00FF → reg4=16'h00FF and busy[4]=1 afterwards.
- RSV on R1 twice in consecutive cycles → RSV_ERR=1 in the cycle after the second RSV only.
- Reserve R0 and R6 and write R6=16'h7777, then assert Reset low for one cycle → all registers 0 and busy_vec 0. Repeat the sweep with NREG=16, DATA_W=32, including index 15 wrap.
